// File: rtl/ahb_uart_pkg.sv
// ahb_uart_pkg: arbiter states and the AHB-Lite encodings shared by the UART bridge arbiter
package ahb_uart_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
endpackage

// File: rtl/ahb_uart_arbiter_rr.sv
// rr_arbiter2: two-way round-robin picker; a tie goes to the side not served last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    last_d = upd ? upd_id : last_q;
    gnt = &req ? (last_q ? 2'b01 : 2'b10) : req;
  end
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
endmodule

// File: rtl/ahb_uart_arbiter.sv
// ahb_uart_arbiter: round-robin AHB-Lite master sharing the UART bridge between CPU and debug ports
module ahb_uart_arbiter
  import ahb_uart_pkg::*;
#(
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  write_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  beat_ack_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  err_o,
  output logic        HSEL_o,
  output logic [1:0]  HTRANS_o,
  output logic        HWRITE_o,
  output logic [31:0] HADDR_o,
  output logic [2:0]  HSIZE_o,
  output logic [2:0]  HBURST_o,
  output logic [31:0] HWDATA_o,
  input  logic        HREADY_i,
  input  logic [1:0]  HRESP_i,
  input  logic [31:0] HRDATA_i
);
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  gnt_q, gnt_d, ack_q, ack_d, err_q, err_d, htrans_q, htrans_d, pick;
  logic [31:0] rdata_q, rdata_d, haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic        hsel_q, hsel_d, hwrite_q, hwrite_d;

  rr_arbiter2 u_rr (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (req_i),
    .upd    (state_q == DONE),
    .upd_id (owner_q),
    .gnt    (pick)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    count_d  = count_q;
    wait_d   = wait_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    hsel_d   = hsel_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d  = ADDR;
        owner_d  = pick[1];
        count_d  = '0;
        gnt_d    = pick;
        hsel_d   = 1'b1;
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = write_i[pick[1]];
        haddr_d  = pick[1] ? addr1_i : addr0_i;
      end
      ADDR: begin
        state_d  = DATA;
        htrans_d = HTRANS_IDLE;
        wait_d   = '0;
        hwdata_d = owner_q ? wdata1_i : wdata0_i;
      end
      DATA: if (HREADY_i) begin
        if (HRESP_i != HRESP_OKAY) begin
          err_d   = gnt_q;
          hsel_d  = 1'b0;
          state_d = DONE;
        end else begin
          ack_d   = gnt_q;
          rdata_d = hwrite_q ? rdata_q : HRDATA_i;
          count_d = count_q + 5'd1;
          // the owner dropping req only ends the burst once the current beat is done
          if (count_q == 5'(BEATS - 1) || !req_i[owner_q]) begin
            hsel_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d  = ADDR;
            htrans_d = HTRANS_SEQ;
            haddr_d  = haddr_q + 32'd4;
          end
        end
      end else if (wait_q == 16'(TIMEOUT - 1)) begin
        err_d   = gnt_q;
        hsel_d  = 1'b0;
        state_d = DONE;
      end else begin
        wait_d = wait_q + 16'd1;
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      count_q  <= '0;
      wait_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign beat_ack_o = ack_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign HSEL_o     = hsel_q;
  assign HTRANS_o   = htrans_q;
  assign HWRITE_o   = hwrite_q;
  assign HADDR_o    = haddr_q;
  assign HWDATA_o   = hwdata_q;
  assign HSIZE_o    = HSIZE_WORD;
  assign HBURST_o   = HBURST_INCR;
endmodule

// File: tb/tb_ahb_uart_arbiter.sv
// tb_ahb_uart_arbiter: scoreboard bench for the UART bridge arbiter (BEATS=4, TIMEOUT=8)
module tb_ahb_uart_arbiter;
  import ahb_uart_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [1:0]  gnt;
  } aexp_t;
  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] rdata;
  } kexp_t;

  localparam logic [111:0] RST_OUTS = {6'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b010, 3'b001};

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req_i = '0, write_i = '0;
  logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0, HRDATA_i = '0;
  logic [1:0]  gnt_o, beat_ack_o, err_o, HTRANS_o, HRESP_i;
  logic [31:0] rdata_o, HADDR_o, HWDATA_o;
  logic [2:0]  HSIZE_o, HBURST_o;
  logic        HSEL_o, HWRITE_o, HREADY_i;

  int checks = 0, failures = 0;
  int ws = 0, err_beat = -1, beat_idx, wcnt;
  bit hang = 1'b0;
  logic [31:0] model_rdata = '0;
  aexp_t exp_addr[$];
  kexp_t exp_ack[$];
  logic [1:0] exp_err[$];

  always #5 clk = ~clk;

  ahb_uart_arbiter #(.BEATS(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_i(write_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .beat_ack_o(beat_ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .HSEL_o(HSEL_o), .HTRANS_o(HTRANS_o), .HWRITE_o(HWRITE_o), .HADDR_o(HADDR_o),
    .HSIZE_o(HSIZE_o), .HBURST_o(HBURST_o), .HWDATA_o(HWDATA_o),
    .HREADY_i(HREADY_i), .HRESP_i(HRESP_i), .HRDATA_i(HRDATA_i)
  );

  function automatic logic [111:0] outs();
    return {gnt_o, beat_ack_o, err_o, rdata_o, HSEL_o, HTRANS_o, HWRITE_o, HADDR_o, HWDATA_o, HSIZE_o, HBURST_o};
  endfunction

  // bridge model: ws wait states per beat, optional error beat, or hang forever
  always @(negedge clk) begin
    if (HTRANS_o != HTRANS_IDLE) begin
      beat_idx = (HTRANS_o == HTRANS_NONSEQ) ? 0 : beat_idx + 1;
      wcnt = 0;
      HREADY_i = 1'b1;
      HRESP_i = HRESP_OKAY;
    end else if (HSEL_o) begin
      HREADY_i = !hang && wcnt >= ws;
      HRESP_i = (HREADY_i && beat_idx == err_beat) ? HRESP_ERROR : HRESP_OKAY;
      wcnt++;
    end else begin
      HREADY_i = 1'b1;
      HRESP_i = HRESP_OKAY;
    end
  end

  // scoreboard: pop an expectation whenever the DUT shows an address phase, ack or error
  always @(negedge clk) begin
    if (HTRANS_o != HTRANS_IDLE) begin
      checks++;
      if (exp_addr.size() == 0) begin
        failures++;
        $display("FAIL addr_phase_unexpected got haddr=%h htrans=%b gnt=%b", HADDR_o, HTRANS_o, gnt_o);
      end else begin
        aexp_t e;
        e = exp_addr.pop_front();
        if ({HADDR_o, HTRANS_o, HWRITE_o, gnt_o, HSEL_o} !== {e.addr, e.trans, e.write, e.gnt, 1'b1}) begin
          failures++;
          $display("FAIL addr_phase got haddr=%h htrans=%b hwrite=%b gnt=%b hsel=%b exp haddr=%h htrans=%b hwrite=%b gnt=%b hsel=1",
                   HADDR_o, HTRANS_o, HWRITE_o, gnt_o, HSEL_o, e.addr, e.trans, e.write, e.gnt);
        end
      end
    end
    if (HSEL_o && HTRANS_o == HTRANS_IDLE && HWRITE_o) begin
      checks++;
      if (HWDATA_o !== (gnt_o[1] ? wdata1_i : wdata0_i)) begin
        failures++;
        $display("FAIL hwdata got=%h exp=%h", HWDATA_o, gnt_o[1] ? wdata1_i : wdata0_i);
      end
    end
    if (beat_ack_o != 2'b00) begin
      checks++;
      if (exp_ack.size() == 0) begin
        failures++;
        $display("FAIL beat_ack_unexpected got=%b", beat_ack_o);
      end else begin
        kexp_t k;
        k = exp_ack.pop_front();
        if ({beat_ack_o, rdata_o} !== {k.who, k.rdata}) begin
          failures++;
          $display("FAIL beat_ack got ack=%b rdata=%h exp ack=%b rdata=%h", beat_ack_o, rdata_o, k.who, k.rdata);
        end
      end
    end
    if (err_o != 2'b00) begin
      checks++;
      if (exp_err.size() == 0) begin
        failures++;
        $display("FAIL err_unexpected got=%b", err_o);
      end else begin
        logic [1:0] w;
        w = exp_err.pop_front();
        if ({err_o, HSEL_o, beat_ack_o} !== {w, 1'b0, 2'b00}) begin
          failures++;
          $display("FAIL err_pulse got err=%b hsel=%b ack=%b exp err=%b hsel=0 ack=00", err_o, HSEL_o, beat_ack_o, w);
        end
      end
    end
  end

  task automatic push_burst(input logic [1:0] who, input logic [31:0] base, input logic wr,
                            input int na, input int nk, input logic [31:0] rd);
    for (int i = 0; i < na; i++)
      exp_addr.push_back(aexp_t'{base + 32'(4 * i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, wr, who});
    for (int i = 0; i < nk; i++) begin
      if (!wr) model_rdata = rd;
      exp_ack.push_back(kexp_t'{who, model_rdata});
    end
  endtask

  // raises the given requests, drops the owner's request in DONE, returns first grant and cycles to gnt low
  task automatic run_burst(input logic [1:0] bits, output logic [1:0] first, output int cyc);
    req_i = req_i | bits;
    first = '0;
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) first = gnt_o;
      if (gnt_o != 2'b00 && !HSEL_o) req_i = req_i & ~gnt_o;
      if (gnt_o == 2'b00) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin failures++; $display("FAIL reset_values got=%h exp=%h", outs(), RST_OUTS); end
    rst_i = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin failures++; $display("FAIL idle_no_req got=%h exp=%h", outs(), RST_OUTS); end
  endtask

  task automatic test_round_robin();
    logic [1:0] f;
    int c;
    write_i = 2'b11; addr0_i = 32'h1000; addr1_i = 32'h2000;
    wdata0_i = 32'hC0C0_0000; wdata1_i = 32'hDB00_0001;
    push_burst(2'b01, 32'h1000, 1'b1, 4, 4, 0);
    push_burst(2'b10, 32'h2000, 1'b1, 4, 4, 0);
    push_burst(2'b01, 32'h1000, 1'b1, 4, 4, 0);
    push_burst(2'b10, 32'h2000, 1'b1, 4, 4, 0);
    run_burst(2'b11, f, c);
    checks += 2;
    if (f !== 2'b01) begin failures++; $display("FAIL rr_first_tie gnt got=%b exp=01", f); end
    if (c != 10) begin failures++; $display("FAIL rr_cpu_burst_cycles got=%0d exp=10", c); end
    run_burst(2'b00, f, c);
    checks += 2;
    if (f !== 2'b10) begin failures++; $display("FAIL rr_debug_after_done gnt got=%b exp=10", f); end
    if (c != 10) begin failures++; $display("FAIL rr_debug_burst_cycles got=%0d exp=10", c); end
    run_burst(2'b11, f, c);
    checks++;
    if (f !== 2'b01) begin failures++; $display("FAIL rr_third_tie gnt got=%b exp=01", f); end
    run_burst(2'b00, f, c);
    checks++;
    if (f !== 2'b10 || c != 10) begin failures++; $display("FAIL rr_debug_drain gnt=%b cycles=%0d exp 10/10", f, c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL rr_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_cpu_write();
    logic [1:0] f;
    int c;
    write_i = 2'b01; addr0_i = 32'h1000; wdata0_i = 32'hCAFE_0001;
    push_burst(2'b01, 32'h1000, 1'b1, 4, 4, 0);
    run_burst(2'b01, f, c);
    checks += 2;
    if (f !== 2'b01) begin failures++; $display("FAIL cpu_write_grant got=%b exp=01", f); end
    if (c != 10) begin failures++; $display("FAIL cpu_write_cycles got=%0d exp=10", c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL cpu_write_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_debug_read();
    logic [1:0] f;
    int c;
    write_i = 2'b00; addr1_i = 32'h2000; ws = 3; HRDATA_i = 32'h0000_00A5;
    push_burst(2'b10, 32'h2000, 1'b0, 4, 4, 32'h0000_00A5);
    run_burst(2'b10, f, c);
    ws = 0;
    checks += 2;
    if (f !== 2'b10) begin failures++; $display("FAIL debug_read_grant got=%b exp=10", f); end
    if (c != 22) begin failures++; $display("FAIL debug_read_cycles got=%0d exp=22", c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL debug_read_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_wrap_drop();
    int n = 0, c = -1;
    write_i = 2'b00; addr0_i = 32'hFFFF_FFFC; HRDATA_i = 32'h1234_5678;
    push_burst(2'b01, 32'hFFFF_FFFC, 1'b0, 2, 2, 32'h1234_5678);
    req_i = 2'b01;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (HTRANS_o != HTRANS_IDLE) n++;
      if (n == 2 && HSEL_o && HTRANS_o == HTRANS_IDLE) req_i = 2'b00;
      if (gnt_o == 2'b00) begin
        c = k;
        break;
      end
    end
    req_i = 2'b00;
    checks++;
    if (c != 6) begin failures++; $display("FAIL wrap_drop_cycles got=%0d exp=6", c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL wrap_drop_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_error();
    logic [1:0] f;
    int c;
    write_i = 2'b01; addr0_i = 32'h3000; wdata0_i = 32'hE000_0002; err_beat = 1;
    push_burst(2'b01, 32'h3000, 1'b1, 2, 1, 0);
    exp_err.push_back(2'b01);
    run_burst(2'b01, f, c);
    err_beat = -1;
    checks++;
    if (c != 6) begin failures++; $display("FAIL error_cycles got=%0d exp=6", c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL error_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_timeout();
    logic [1:0] f;
    int c;
    write_i = 2'b01; addr0_i = 32'h4000; wdata0_i = 32'h7100_0003; hang = 1'b1;
    push_burst(2'b01, 32'h4000, 1'b1, 1, 0, 0);
    exp_err.push_back(2'b01);
    run_burst(2'b01, f, c);
    hang = 1'b0;
    checks++;
    if (c != 11) begin failures++; $display("FAIL timeout_cycles got=%0d exp=11", c); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL timeout_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] f;
    int c, n = 0;
    bit hit = 1'b0;
    write_i = 2'b01; addr0_i = 32'h5000; wdata0_i = 32'h5EED_0004;
    push_burst(2'b01, 32'h5000, 1'b1, 3, 2, 0);
    req_i = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (HTRANS_o != HTRANS_IDLE) n++;
      if (n == 3 && HSEL_o && HTRANS_o == HTRANS_IDLE) begin
        rst_i = 1'b1;
        req_i = 2'b00;
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_mid_reach_beat3 got=0 exp=1"); end
    @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin failures++; $display("FAIL reset_mid_values got=%h exp=%h", outs(), RST_OUTS); end
    rst_i = 1'b0;
    model_rdata = '0;
    write_i = 2'b11; addr0_i = 32'h6000; addr1_i = 32'h7000;
    push_burst(2'b01, 32'h6000, 1'b1, 4, 4, 0);
    push_burst(2'b10, 32'h7000, 1'b1, 4, 4, 0);
    run_burst(2'b11, f, c);
    checks++;
    if (f !== 2'b01 || c != 10) begin failures++; $display("FAIL reset_mid_tie gnt=%b cycles=%0d exp 01/10", f, c); end
    run_burst(2'b00, f, c);
    checks++;
    if (f !== 2'b10) begin failures++; $display("FAIL reset_mid_debug gnt got=%b exp=10", f); end
    checks++;
    if (exp_addr.size() + exp_ack.size() + exp_err.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_leftover addr=%0d ack=%0d err=%0d exp=0", exp_addr.size(), exp_ack.size(), exp_err.size());
      exp_addr.delete(); exp_ack.delete(); exp_err.delete();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_cpu_write();
    test_debug_read();
    test_wrap_drop();
    test_error();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
